core_ctrl_fsm: RTL and testbench

- Multi-cycle sequencer for the NPC core.
- Fetches an instruction over a valid/ready handshake and latches it.
- Drives the decoder's 3-bit immediate-format select, sequences the memory access for loads/stores, then issues register-file and PC write strobes.
- Sits between the IFU/LSU bus ports and the decode/execute datapath; one instruction in flight at a time.

---
 rtl/core_pkg.sv | 46 ++++
 rtl/core_opdec.sv | 62 ++++++
 rtl/core_ctrl_fsm.sv | 150 +++++++++++++++
 tb/tb_core_ctrl_fsm.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared constants and types for the NPC control sequencer.
// Holds opcodes, immediate-format codes, the EBREAK word and FSM states.
package core_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] INST_TYPE_I = 3'b000;
    localparam logic [2:0] INST_TYPE_U = 3'b001;
    localparam logic [2:0] INST_TYPE_S = 3'b010;
    localparam logic [2:0] INST_TYPE_B = 3'b011;
    localparam logic [2:0] INST_TYPE_J = 3'b100;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_FETCH     = 4'd1;
    localparam state_t ST_WAIT_INST = 4'd2;
    localparam state_t ST_DECODE    = 4'd3;
    localparam state_t ST_EXEC      = 4'd4;
    localparam state_t ST_MEM_REQ   = 4'd5;
    localparam state_t ST_MEM_WAIT  = 4'd6;
    localparam state_t ST_WB        = 4'd7;
    localparam state_t ST_HALT      = 4'd8;
    localparam state_t ST_TRAP      = 4'd9;

    typedef struct packed {
        logic [2:0] inst_type;
        logic       writes_rd;
        logic       is_mem;
        logic       is_store;
        logic       is_ebreak;
        logic       legal;
    } opdec_t;

endpackage

// File: rtl/core_opdec.sv
// core_opdec: combinational opcode classifier for the control sequencer.
// Ports: inst (32b instruction) in; dec (opdec_t class bundle) out.
module core_opdec
    import core_pkg::*;
(
    input  logic [31:0] inst,
    output opdec_t      dec
);

    logic [6:0] op;

    assign op = inst[6:0];

    always_comb begin
        dec = '0;
        unique case (1'b1)
            (op == OP_LUI),
            (op == OP_AUIPC): begin
                dec.inst_type = INST_TYPE_U;
                dec.writes_rd = 1'b1;
                dec.legal     = 1'b1;
            end
            (op == OP_JAL): begin
                dec.inst_type = INST_TYPE_J;
                dec.writes_rd = 1'b1;
                dec.legal     = 1'b1;
            end
            (op == OP_JALR),
            (op == OP_IMM),
            (op == OP_REG): begin
                dec.inst_type = INST_TYPE_I;
                dec.writes_rd = 1'b1;
                dec.legal     = 1'b1;
            end
            (op == OP_BRANCH): begin
                dec.inst_type = INST_TYPE_B;
                dec.legal     = 1'b1;
            end
            (op == OP_LOAD): begin
                dec.inst_type = INST_TYPE_I;
                dec.writes_rd = 1'b1;
                dec.is_mem    = 1'b1;
                dec.legal     = 1'b1;
            end
            (op == OP_STORE): begin
                dec.inst_type = INST_TYPE_S;
                dec.is_mem    = 1'b1;
                dec.is_store  = 1'b1;
                dec.legal     = 1'b1;
            end
            (op == OP_SYSTEM): begin
                // Only ebreak is supported from the SYSTEM space.
                dec.is_ebreak = (inst == EBREAK);
                dec.legal     = (inst == EBREAK);
            end
            default: begin
                dec.legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle fetch/decode/mem/writeback sequencer.
// Ports: clk, rst (async high); ifu_* fetch handshake; inst, inst_type
// to decode; lsu_* memory handshake; rf_we, pc_we strobes; halt, trap.
// Optional macro CORE_CTRL_PERF_EN adds perf_cycle and perf_instret.
module core_ctrl_fsm
    import core_pkg::*;
#(
    parameter int unsigned RESET_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic [31:0] inst,
    output logic [2:0]  inst_type,
    output logic        lsu_req_valid,
    output logic        lsu_req_we,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        rf_we,
    output logic        pc_we,
    output logic        halt,
    output logic        trap
`ifdef CORE_CTRL_PERF_EN
    ,
    output logic [63:0] perf_cycle,
    output logic [63:0] perf_instret
`else
`endif
);

    localparam logic [3:0] WAIT_LAST = 4'(RESET_WAIT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    opdec_t     dec;
    logic       in_dec;

    core_opdec u_opdec (
        .inst (inst),
        .dec  (dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            inst     <= 32'd0;
        end else begin
            state <= state_nxt;
            // IDLE is only reachable via reset, so the counter
            // never needs to be cleared outside reset.
            if (state == ST_IDLE && wait_cnt != WAIT_LAST)
                wait_cnt <= wait_cnt + 4'd1;
            if (state == ST_WAIT_INST && ifu_rsp_valid)
                inst <= ifu_rsp_inst;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (wait_cnt == WAIT_LAST)
                    state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (ifu_req_ready)
                    state_nxt = ST_WAIT_INST;
            end
            ST_WAIT_INST: begin
                if (ifu_rsp_valid)
                    state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec.is_ebreak)
                    state_nxt = ST_HALT;
                else if (!dec.legal)
                    state_nxt = ST_TRAP;
                else
                    state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = dec.is_mem ? ST_MEM_REQ : ST_WB;
            end
            ST_MEM_REQ: begin
                // A response in the accept cycle is ignored here;
                // MEM_WAIT waits for a later one.
                if (lsu_req_ready)
                    state_nxt = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (lsu_rsp_valid)
                    state_nxt = ST_WB;
            end
            ST_WB: begin
                state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            ST_TRAP: begin
                state_nxt = ST_TRAP;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign in_dec = (state == ST_DECODE)
                 || (state == ST_EXEC)
                 || (state == ST_MEM_REQ)
                 || (state == ST_MEM_WAIT)
                 || (state == ST_WB);

    assign inst_type     = in_dec ? dec.inst_type : INST_TYPE_I;
    assign ifu_req_valid = (state == ST_FETCH);
    assign lsu_req_valid = (state == ST_MEM_REQ);
    assign lsu_req_we    = (state == ST_MEM_REQ) && dec.is_store;
    assign pc_we         = (state == ST_WB);
    assign rf_we         = (state == ST_WB) && dec.writes_rd;
    assign halt          = (state == ST_HALT);
    assign trap          = (state == ST_TRAP);

`ifdef CORE_CTRL_PERF_EN
    logic run_cycle;

    assign run_cycle = (state != ST_IDLE)
                    && (state != ST_HALT)
                    && (state != ST_TRAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycle   <= 64'd0;
            perf_instret <= 64'd0;
        end else begin
            if (run_cycle)
                perf_cycle <= perf_cycle + 64'd1;
            if (state == ST_WB)
                perf_instret <= perf_instret + 64'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb_core_ctrl_fsm: scoreboard bench for core_ctrl_fsm.
// Stimulus pushes expected retire/halt/trap events; a monitor pops them.
module tb_core_ctrl_fsm;
    import core_pkg::*;

    localparam int RW = 3;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_SW   = 32'h0011_2023;
    localparam logic [31:0] I_JAL  = 32'h0080_00EF;
    localparam logic [31:0] I_BEQ  = 32'h0000_0463;
    localparam logic [31:0] I_LW   = 32'h0000_2083;
    localparam logic [31:0] I_ILL  = 32'h0000_007F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid;
    logic        ifu_req_ready = 1'b0;
    logic        ifu_rsp_valid = 1'b0;
    logic [31:0] ifu_rsp_inst = 32'd0;
    logic [31:0] inst;
    logic [2:0]  inst_type;
    logic        lsu_req_valid;
    logic        lsu_req_we;
    logic        lsu_req_ready = 1'b0;
    logic        lsu_rsp_valid = 1'b0;
    logic        rf_we;
    logic        pc_we;
    logic        halt;
    logic        trap;
`ifdef CORE_CTRL_PERF_EN
    logic [63:0] perf_cycle;
    logic [63:0] perf_instret;
`endif

    core_ctrl_fsm #(.RESET_WAIT(RW)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_inst  (ifu_rsp_inst),
        .inst          (inst),
        .inst_type     (inst_type),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_we    (lsu_req_we),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .rf_we         (rf_we),
        .pc_we         (pc_we),
        .halt          (halt),
`ifdef CORE_CTRL_PERF_EN
        .trap          (trap),
        .perf_cycle    (perf_cycle),
        .perf_instret  (perf_instret)
`else
        .trap          (trap)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_fail = 0;

    typedef struct {
        int          kind;
        logic [31:0] inst;
        logic [2:0]  ty;
        logic        rf;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int kind);
        exp_t e;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: event kind %0d, expected none", kind);
        end else begin
            e = sbq.pop_front();
            chk("sb_kind", 64'(kind), 64'(e.kind));
            if (kind == 0) begin
                chk("sb_inst", inst, e.inst);
                chk("sb_type", inst_type, e.ty);
                chk("sb_rf_we", rf_we, e.rf);
            end
        end
    endtask

    initial begin
        logic halt_q = 1'b0;
        logic trap_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pc_we) sb_pop(0);
                if (halt && !halt_q) sb_pop(1);
                if (trap && !trap_q) sb_pop(2);
            end
            halt_q = halt;
            trap_q = trap;
        end
    end

    function automatic logic sig(input int which);
        case (which)
            0:       return ifu_req_valid;
            1:       return lsu_req_valid;
            default: return pc_we;
        endcase
    endfunction

    task automatic wait_for(input int which, input string name);
        int n = 0;
        while (!sig(which) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!sig(which)) begin
            n_fail++;
            $display("FAIL %s: timeout %0d cycles, wanted signal %0d high",
                     name, n, which);
        end
    endtask

    // Called on a negedge; leaves the bench on the first FETCH negedge.
    task automatic do_reset(input logic late_rsp);
        int n = 0;
        int pc_seen = 0;
        rst = 1'b1;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = late_rsp;
        ifu_rsp_inst  = I_ILL;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = late_rsp;
        sbq.delete();
        #1;
        chk("rst_outs", {ifu_req_valid, lsu_req_valid, lsu_req_we,
                         rf_we, pc_we, halt, trap, inst_type}, 64'd0);
        chk("rst_inst", inst, 32'd0);
`ifdef CORE_CTRL_PERF_EN
        chk("rst_perf", perf_cycle | perf_instret, 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ifu_rsp_valid = 1'b0;
        while (!ifu_req_valid && n < 50) begin
            @(negedge clk);
            n++;
            pc_seen += int'(pc_we);
        end
        lsu_rsp_valid = 1'b0;
        chk("reset_wait", 64'(n), 64'(RW));
        if (late_rsp) chk("late_rsp_ignored", 64'(pc_seen), 64'd0);
    endtask

    task automatic fetch(input logic [31:0] w, input int d);
        repeat (d) @(negedge clk);
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = w;
        @(negedge clk);
        ifu_rsp_valid = 1'b0;
    endtask

    task automatic mem_access(input int d, input logic st, input logic both,
                              input string name);
        int hi = 0;
        int we_bad = 0;
        wait_for(1, name);
        repeat (d) begin
            hi += int'(lsu_req_valid);
            if (lsu_req_we !== st) we_bad++;
            @(negedge clk);
        end
        hi += int'(lsu_req_valid);
        if (lsu_req_we !== st) we_bad++;
        lsu_req_ready = 1'b1;
        lsu_rsp_valid = both;
        @(negedge clk);
        lsu_req_ready = 1'b0;
        chk({name, "_valid_hold"}, 64'(hi), 64'(d + 1));
        chk({name, "_we"}, 64'(we_bad), 64'd0);
        chk({name, "_wait_valid"}, lsu_req_valid, 1'b0);
        lsu_rsp_valid = 1'b1;
        @(negedge clk);
        lsu_rsp_valid = 1'b0;
    endtask

    task automatic run(input logic [31:0] w, input logic [2:0] ty,
                       input logic rf, input int rdy_dly, input int lsu_dly,
                       input logic both, input int exp_lat,
                       input string name);
        int t0;
        sbq.push_back('{0, w, ty, rf});
        wait_for(0, name);
        chk({name, "_fetch_type"}, inst_type, INST_TYPE_I);
        t0 = cyc;
        fetch(w, rdy_dly);
        if (lsu_dly >= 0)
            mem_access(lsu_dly, w[6:0] == OP_STORE, both, name);
        wait_for(2, name);
        chk({name, "_lat"}, 64'(cyc - t0), 64'(exp_lat));
    endtask

    task automatic terminal(input logic [31:0] w, input int kind,
                            input string name);
        int fetches = 0;
        sbq.push_back('{kind, w, 3'd0, 1'b0});
        wait_for(0, name);
        fetch(w, 0);
        chk({name, "_decode_flag"}, {halt, trap}, 2'b00);
        @(negedge clk);
        chk({name, "_flags"}, {halt, trap},
            (kind == 1) ? 2'b10 : 2'b01);
        chk({name, "_type"}, inst_type, INST_TYPE_I);
        repeat (6) begin
            @(negedge clk);
            fetches += int'(ifu_req_valid | pc_we | lsu_req_valid);
        end
        chk({name, "_quiet"}, 64'(fetches), 64'd0);
        chk({name, "_sticky"}, {halt, trap},
            (kind == 1) ? 2'b10 : 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset(1'b0);
        run(I_ADDI, INST_TYPE_I, 1'b1, 0, -1, 1'b0, 4, "addi");
        run(I_SW,   INST_TYPE_S, 1'b0, 0,  3, 1'b0, 9, "sw");
        run(I_JAL,  INST_TYPE_J, 1'b1, 2, -1, 1'b0, 6, "jal");
        run(I_BEQ,  INST_TYPE_B, 1'b0, 0, -1, 1'b0, 4, "beq");
        run(I_LW,   INST_TYPE_I, 1'b1, 0,  0, 1'b1, 6, "lw");

        // Reset pulsed while a load sits in MEM_WAIT.
        wait_for(0, "mw_fetch");
        fetch(I_LW, 0);
        wait_for(1, "mw_req");
        lsu_req_ready = 1'b1;
        @(negedge clk);
        lsu_req_ready = 1'b0;
        do_reset(1'b1);

        terminal(I_ILL, 2, "trap");
        @(negedge clk);
        do_reset(1'b0);
        terminal(EBREAK, 1, "halt");

`ifdef CORE_CTRL_PERF_EN
        @(negedge clk);
        do_reset(1'b0);
        run(I_ADDI, INST_TYPE_I, 1'b1, 0, -1, 1'b0, 4, "p_addi0");
        run(I_ADDI, INST_TYPE_I, 1'b1, 0, -1, 1'b0, 4, "p_addi1");
        run(I_ADDI, INST_TYPE_I, 1'b1, 0, -1, 1'b0, 4, "p_addi2");
        sbq.push_back('{1, EBREAK, 3'd0, 1'b0});
        wait_for(0, "p_ebreak");
        fetch(EBREAK, 0);
        @(negedge clk);
        chk("perf_instret", perf_instret, 64'd3);
        chk("perf_cycle", perf_cycle, 64'd18);
        repeat (3) @(negedge clk);
        chk("perf_cycle_frozen", perf_cycle, 64'd18);
`endif

        @(negedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
